// File: rtl/rob_flushable_if.sv
// rob_flushable_if: every signal of the reorder buffer except clock and reset.
//   slave  : ROB side (issue, CDB, decode, load-check and flush inputs; status and head outputs)
//   master : environment side (drives the inputs, observes the outputs)
// PTR_W is derived from DEPTH. The instantiating module must use the same parameter values.
interface rob_flushable_if #(
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32,
  parameter int NUM_CDB = 2,
  parameter int NUM_LD  = 3
);
  localparam int PTR_W = $clog2(DEPTH);

  logic                        valid_in;
  logic [3:0]                  iType_in;
  logic [DATA_W-1:0]           value_in;
  logic [DATA_W-1:0]           dest_in;
  logic                        ready_out;
  logic [PTR_W-1:0]            inst_rob_ix_out;
  logic [NUM_CDB-1:0]          cdb_valid_in;
  logic [NUM_CDB*PTR_W-1:0]    cdb_rob_ix_in;
  logic [NUM_CDB*DATA_W-1:0]   cdb_value_in;
  logic [NUM_CDB*DATA_W-1:0]   cdb_dest_in;
  logic [2*PTR_W-1:0]          dec_ix_in;
  logic [2*DATA_W-1:0]         dec_value_out;
  logic [1:0]                  dec_ready_out;
  logic [NUM_LD*PTR_W-1:0]     ld_ix_in;
  logic [NUM_LD*DATA_W-1:0]    ld_addr_in;
  logic [NUM_LD-1:0]           can_load_out;
  logic                        commit_valid_out;
  logic                        commit_ready_in;
  logic                        store_valid_out;
  logic                        store_read_in;
  logic [PTR_W-1:0]            ix_out;
  logic [3:0]                  iType_out;
  logic [DATA_W-1:0]           value_out;
  logic [DATA_W-1:0]           dest_out;
  logic                        flush_in;
  logic [PTR_W-1:0]            flush_ix_in;
  logic [PTR_W:0]              count_out;

  modport slave (
    input  valid_in, iType_in, value_in, dest_in,
    input  cdb_valid_in, cdb_rob_ix_in, cdb_value_in, cdb_dest_in,
    input  dec_ix_in, ld_ix_in, ld_addr_in,
    input  commit_ready_in, store_read_in, flush_in, flush_ix_in,
    output ready_out, inst_rob_ix_out, dec_value_out, dec_ready_out, can_load_out,
    output commit_valid_out, store_valid_out, ix_out, iType_out, value_out, dest_out,
    output count_out
  );

  modport master (
    output valid_in, iType_in, value_in, dest_in,
    output cdb_valid_in, cdb_rob_ix_in, cdb_value_in, cdb_dest_in,
    output dec_ix_in, ld_ix_in, ld_addr_in,
    output commit_ready_in, store_read_in, flush_in, flush_ix_in,
    input  ready_out, inst_rob_ix_out, dec_value_out, dec_ready_out, can_load_out,
    input  commit_valid_out, store_valid_out, ix_out, iType_out, value_out, dest_out,
    input  count_out
  );
endinterface

// File: rtl/rob_flushable.sv
// rob_flushable: circular reorder buffer with DEPTH entries sitting between issue,
// the CDB and commit. It also performs operand lookup with CDB bypass, checks load
// ordering against older stores (aware of wrap-around), and flushes on a mispredict.
// Ports:
//   clk_in  - clock
//   rst_in  - synchronous active-high reset
//   bus     - rob_flushable_if.slave, which carries issue, CDB, decode lookup,
//             load check, commit/store retire, flush and count
module rob_flushable #(
  parameter int         DEPTH   = 8,
  parameter int         DATA_W  = 32,
  parameter int         NUM_CDB = 2,
  parameter int         NUM_LD  = 3,
  parameter logic [3:0] STORE_T = 4'd3
) (
  input  logic           clk_in,
  input  logic           rst_in,
  rob_flushable_if.slave bus
);
  localparam int             PTR_W   = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL    = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] ONE   = PTR_W'(1);

  logic [PTR_W-1:0]  r_head, r_tail;
  logic [PTR_W:0]    r_count;
  logic [DEPTH-1:0]  r_valid, r_ready;
  logic [3:0]        r_itype [DEPTH];
  logic [DATA_W-1:0] r_value [DEPTH];
  logic [DATA_W-1:0] r_dest  [DEPTH];

  logic              w_ready, w_issue, w_commit_valid, w_store_valid, w_retire;
  logic [PTR_W-1:0]  w_flush_age;
  logic [DEPTH-1:0]  w_cdb_hit, w_squash;
  logic [DATA_W-1:0] w_cdb_val [DEPTH];
  logic [DATA_W-1:0] w_cdb_off [DEPTH];

  // An entry's age is its distance from head, so ordering is still correct after the pointers wrap.
  function automatic logic [PTR_W-1:0] f_age(input logic [PTR_W-1:0] ix, input logic [PTR_W-1:0] hd);
    return ix - hd;
  endfunction

  assign w_ready        = r_count < FULL;
  assign w_issue        = bus.valid_in && w_ready && !bus.flush_in;
  assign w_commit_valid = (r_count != '0) && r_ready[r_head] && (r_itype[r_head] != STORE_T);
  assign w_store_valid  = (r_count != '0) && r_ready[r_head] && (r_itype[r_head] == STORE_T);
  assign w_retire       = (w_commit_valid && bus.commit_ready_in) || (w_store_valid && bus.store_read_in);
  assign w_flush_age    = f_age(bus.flush_ix_in, r_head);

  assign bus.ready_out        = w_ready;
  assign bus.inst_rob_ix_out  = r_tail;
  assign bus.commit_valid_out = w_commit_valid;
  assign bus.store_valid_out  = w_store_valid;
  assign bus.ix_out           = r_head;
  assign bus.iType_out        = r_itype[r_head];
  assign bus.value_out        = r_value[r_head];
  assign bus.dest_out         = r_dest[r_head];
  assign bus.count_out        = r_count;

  // Resolve CDB hits per entry. Ports are scanned from the highest index down, so the lowest port is written last and wins.
  always_comb begin
    w_cdb_hit = '0;
    w_squash  = '0;
    for (int j = 0; j < DEPTH; j++) begin
      w_cdb_val[j] = '0;
      w_cdb_off[j] = '0;
      w_squash[j]  = bus.flush_in && (f_age(PTR_W'(j), r_head) > w_flush_age);
    end
    for (int p = NUM_CDB-1; p >= 0; p--) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (bus.cdb_valid_in[p] && (bus.cdb_rob_ix_in[p*PTR_W +: PTR_W] == PTR_W'(j))) begin
          w_cdb_hit[j] = 1'b1;
          w_cdb_val[j] = bus.cdb_value_in[p*DATA_W +: DATA_W];
          w_cdb_off[j] = bus.cdb_dest_in[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    bus.dec_value_out = '0;
    bus.dec_ready_out = '0;
    for (int d = 0; d < 2; d++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (bus.dec_ix_in[d*PTR_W +: PTR_W] == PTR_W'(j)) begin
          if (r_valid[j] && w_cdb_hit[j]) begin
            bus.dec_value_out[d*DATA_W +: DATA_W] = w_cdb_val[j];
            bus.dec_ready_out[d]                  = 1'b1;
          end else begin
            bus.dec_value_out[d*DATA_W +: DATA_W] = r_value[j];
            bus.dec_ready_out[d]                  = r_ready[j];
          end
        end
      end
    end
  end

  // A load is blocked by any older store whose address is still unresolved, or whose address matches the load's.
  always_comb begin
    bus.can_load_out = '1;
    for (int k = 0; k < NUM_LD; k++) begin
      for (int j = 0; j < DEPTH; j++) begin
        if (r_valid[j] && (r_itype[j] == STORE_T) &&
            (f_age(PTR_W'(j), r_head) < f_age(bus.ld_ix_in[k*PTR_W +: PTR_W], r_head)) &&
            (!r_ready[j] || (r_dest[j] == bus.ld_addr_in[k*DATA_W +: DATA_W])))
          bus.can_load_out[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_valid <= '0;
      r_ready <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        r_itype[j] <= '0;
        r_value[j] <= '0;
        r_dest[j]  <= '0;
      end
    end else begin
      // The valid check also drops a CDB write aimed at the slot being issued this cycle.
      for (int j = 0; j < DEPTH; j++) begin
        if (w_cdb_hit[j] && r_valid[j] && !w_squash[j]) begin
          r_value[j] <= w_cdb_val[j];
          r_ready[j] <= 1'b1;
          if (r_itype[j] == STORE_T)
            r_dest[j] <= r_dest[j] + w_cdb_off[j];
        end
      end
      if (w_issue) begin
        r_valid[r_tail] <= 1'b1;
        r_ready[r_tail] <= 1'b0;
        r_itype[r_tail] <= bus.iType_in;
        r_value[r_tail] <= bus.value_in;
        r_dest[r_tail]  <= bus.dest_in;
        r_tail          <= r_tail + ONE;
      end
      if (w_retire) begin
        r_valid[r_head] <= 1'b0;
        r_ready[r_head] <= 1'b0;
        r_head          <= r_head + ONE;
      end
      if (bus.flush_in) begin
        for (int j = 0; j < DEPTH; j++) begin
          if (w_squash[j]) begin
            r_valid[j] <= 1'b0;
            r_ready[j] <= 1'b0;
          end
        end
        r_tail  <= bus.flush_ix_in + ONE;
        r_count <= {1'b0, w_flush_age} + CNT_ONE - {{PTR_W{1'b0}}, w_retire};
      end else begin
        r_count <= r_count + {{PTR_W{1'b0}}, w_issue} - {{PTR_W{1'b0}}, w_retire};
      end
    end
  end
endmodule

// File: tb/tb_rob_flushable.sv
module tb_rob_flushable;
  localparam int DEPTH = 8, DATA_W = 32, NUM_CDB = 2, NUM_LD = 3;
  localparam logic [3:0] ALU = 4'd0, LDT = 4'd2, ST = 4'd3;

  typedef struct packed {
    logic [2:0] ix;
    logic [3:0] ity;
  } rec_t;

  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  int   tests  = 0;
  int   fails  = 0;

  rec_t        sb[$];
  logic [31:0] mv [8];
  logic [31:0] md [8];
  logic [3:0]  mt [8];
  logic [2:0]  etail;

  rob_flushable_if #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB), .NUM_LD(NUM_LD)) bus ();

  rob_flushable #(.DEPTH(DEPTH), .DATA_W(DATA_W), .NUM_CDB(NUM_CDB), .NUM_LD(NUM_LD), .STORE_T(ST)) dut (
    .clk_in(clk_in),
    .rst_in(rst_in),
    .bus   (bus)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic clear_inputs();
    bus.valid_in = 0; bus.iType_in = '0; bus.value_in = '0; bus.dest_in = '0;
    bus.cdb_valid_in = '0; bus.cdb_rob_ix_in = '0; bus.cdb_value_in = '0; bus.cdb_dest_in = '0;
    bus.dec_ix_in = '0; bus.ld_ix_in = '0; bus.ld_addr_in = '0;
    bus.commit_ready_in = 0; bus.store_read_in = 0; bus.flush_in = 0; bus.flush_ix_in = '0;
  endtask

  task automatic issue(input logic [3:0] ity, input logic [31:0] val, input logic [31:0] dst);
    rec_t r;
    bus.valid_in = 1; bus.iType_in = ity; bus.value_in = val; bus.dest_in = dst;
    #1;
    chk("issue_ix", bus.inst_rob_ix_out, etail);
    chk("issue_ready", bus.ready_out, 1);
    r.ix = etail; r.ity = ity;
    sb.push_back(r);
    mt[etail] = ity; mv[etail] = val; md[etail] = dst;
    tick();
    bus.valid_in = 0;
    etail = etail + 3'd1;
  endtask

  task automatic cdb(input logic [2:0] ix, input logic [31:0] val, input logic [31:0] off);
    bus.cdb_valid_in = 2'b01;
    bus.cdb_rob_ix_in[2:0] = ix;
    bus.cdb_value_in[31:0] = val;
    bus.cdb_dest_in[31:0]  = off;
    mv[ix] = val;
    if (mt[ix] == ST) md[ix] = md[ix] + off;
    tick();
    bus.cdb_valid_in = '0;
  endtask

  task automatic retire();
    rec_t r;
    chk("sb_nonempty", 64'(sb.size() != 0), 1);
    if (sb.size() == 0) return;
    r = sb.pop_front();
    if (r.ity == ST) begin
      chk("store_valid", bus.store_valid_out, 1);
      chk("commit_valid_st", bus.commit_valid_out, 0);
      bus.store_read_in = 1;
    end else begin
      chk("commit_valid", bus.commit_valid_out, 1);
      chk("store_valid_alu", bus.store_valid_out, 0);
      bus.commit_ready_in = 1;
    end
    chk("head_ix", bus.ix_out, r.ix);
    chk("head_type", bus.iType_out, r.ity);
    chk("head_value", bus.value_out, mv[r.ix]);
    chk("head_dest", bus.dest_out, md[r.ix]);
    tick();
    bus.store_read_in = 0;
    bus.commit_ready_in = 0;
  endtask

  initial begin
    rec_t r;
    clear_inputs();
    etail = '0;
    rst_in = 1;
    tick(); tick();
    rst_in = 0;
    #1;
    chk("rst_ready", bus.ready_out, 1);
    chk("rst_commit_valid", bus.commit_valid_out, 0);
    chk("rst_store_valid", bus.store_valid_out, 0);
    chk("rst_can_load", bus.can_load_out, 3'b111);
    chk("rst_count", bus.count_out, 0);

    // Fill all entries; a ninth issue is dropped
    for (int i = 0; i < 8; i++) issue(ALU, 32'hA000 + i, i);
    chk("full_count", bus.count_out, 8);
    chk("full_ready", bus.ready_out, 0);
    bus.valid_in = 1; bus.value_in = 32'hBAD;
    tick();
    bus.valid_in = 0;
    chk("drop9_count", bus.count_out, 8);
    chk("drop9_tail", bus.inst_rob_ix_out, etail);

    // Two ports hit entry 3: port 0 wins, and the decode lookup bypasses the CDB value
    bus.cdb_valid_in = 2'b11;
    bus.cdb_rob_ix_in = {3'd3, 3'd3};
    bus.cdb_value_in = {32'd9, 32'd5};
    bus.dec_ix_in = {3'd2, 3'd3};
    #1;
    chk("byp3_value", bus.dec_value_out[31:0], 5);
    chk("byp3_ready", bus.dec_ready_out[0], 1);
    chk("dec2_value", bus.dec_value_out[63:32], 32'hA002);
    chk("dec2_ready", bus.dec_ready_out[1], 0);
    mv[3] = 5;
    tick();
    bus.cdb_valid_in = '0;
    chk("val3_value", bus.dec_value_out[31:0], 5);
    chk("val3_ready", bus.dec_ready_out[0], 1);

    // Port 1 broadcasts 0x55 to entry 2 while it is being looked up
    bus.cdb_valid_in = 2'b10;
    bus.cdb_rob_ix_in = {3'd2, 3'd0};
    bus.cdb_value_in = {32'h55, 32'h0};
    #1;
    chk("byp2_value", bus.dec_value_out[63:32], 32'h55);
    chk("byp2_ready", bus.dec_ready_out[1], 1);
    mv[2] = 32'h55;
    tick();
    bus.cdb_valid_in = '0;

    chk("head_not_ready", bus.commit_valid_out, 0);
    cdb(3'd0, 32'hC0, 0);
    retire();
    chk("commit_one_cycle", bus.commit_valid_out, 0);
    chk("count_after_commit", bus.count_out, 7);

    // Issue and commit in the same cycle while not full: the count stays the same
    cdb(3'd1, 32'hC1, 0);
    r = sb.pop_front();
    chk("ic_commit_valid", bus.commit_valid_out, 1);
    chk("ic_head_ix", bus.ix_out, r.ix);
    chk("ic_head_value", bus.value_out, mv[r.ix]);
    r.ix = etail; r.ity = ALU;
    sb.push_back(r);
    mt[etail] = ALU; mv[etail] = 32'hE0; md[etail] = 32'hE;
    bus.valid_in = 1; bus.iType_in = ALU; bus.value_in = 32'hE0; bus.dest_in = 32'hE;
    bus.commit_ready_in = 1;
    #1;
    chk("ic_issue_ix", bus.inst_rob_ix_out, etail);
    tick();
    bus.valid_in = 0; bus.commit_ready_in = 0;
    etail = etail + 3'd1;
    chk("ic_count", bus.count_out, 7);

    // When full, a commit does not let an issue through in the same cycle
    issue(ALU, 32'hE1, 32'hF);
    chk("refull_count", bus.count_out, 8);
    bus.valid_in = 1;
    retire();
    bus.valid_in = 0;
    chk("full_commit_count", bus.count_out, 7);
    chk("full_commit_tail", bus.inst_rob_ix_out, etail);
    chk("full_commit_ready", bus.ready_out, 1);

    // Reset in the middle of activity
    rst_in = 1;
    bus.valid_in = 1;
    tick();
    rst_in = 0; bus.valid_in = 0;
    sb.delete(); etail = '0;
    chk("mrst_count", bus.count_out, 0);
    chk("mrst_ready", bus.ready_out, 1);
    chk("mrst_commit_valid", bus.commit_valid_out, 0);
    chk("mrst_tail", bus.inst_rob_ix_out, 0);

    // Advance head to 6, then test load ordering against a store whose address is unresolved
    for (int i = 0; i < 6; i++) issue(ALU, 32'h10 + i, 32'h20 + i);
    for (int i = 0; i < 6; i++) cdb(3'(i), 32'hB0 + i, 0);
    for (int i = 0; i < 6; i++) retire();
    issue(ALU, 32'h1, 32'h6);
    issue(ST, 32'h0, 32'h100);
    issue(ALU, 32'h2, 32'h7);
    issue(LDT, 32'h3, 32'h8);
    bus.ld_ix_in = {3'd1, 3'd7, 3'd1};
    bus.ld_addr_in = {32'h200, 32'h104, 32'h104};
    #1;
    chk("ld_unresolved", bus.can_load_out, 3'b010);
    cdb(3'd7, 32'hDEAD, 32'h4);
    chk("ld_resolved", bus.can_load_out, 3'b110);
    cdb(3'd6, 32'h66, 0);
    cdb(3'd0, 32'h60, 0);
    cdb(3'd1, 32'h61, 0);
    retire();
    chk("ld_store_at_head", bus.can_load_out, 3'b110);
    retire();
    chk("ld_store_gone", bus.can_load_out, 3'b111);
    retire();
    retire();
    bus.ld_ix_in = '0; bus.ld_addr_in = '0;
    chk("drain_count", bus.count_out, 0);

    // Flush: head=2, six entries, mispredicted branch at 4
    for (int i = 0; i < 6; i++) issue(ALU, 32'h40 + i, i);
    chk("pre_flush_count", bus.count_out, 6);
    bus.flush_in = 1; bus.flush_ix_in = 3'd4;
    bus.valid_in = 1; bus.value_in = 32'hBAD;
    bus.cdb_valid_in = 2'b01; bus.cdb_rob_ix_in = {3'd0, 3'd6}; bus.cdb_value_in = {32'h0, 32'h66};
    tick();
    clear_inputs();
    void'(sb.pop_back()); void'(sb.pop_back()); void'(sb.pop_back());
    etail = 3'd5;
    chk("flush_count", bus.count_out, 3);
    chk("flush_tail", bus.inst_rob_ix_out, 5);
    bus.dec_ix_in = {3'd5, 3'd6};
    bus.cdb_valid_in = 2'b01; bus.cdb_rob_ix_in = {3'd0, 3'd6}; bus.cdb_value_in = {32'h0, 32'h77};
    #1;
    chk("squash6_ready", bus.dec_ready_out[0], 0);
    chk("squash6_value", bus.dec_value_out[31:0], 32'h44);
    chk("squash5_ready", bus.dec_ready_out[1], 0);
    tick();
    bus.cdb_valid_in = '0;
    chk("cdb6_ignored", bus.dec_ready_out[0], 0);
    issue(ALU, 32'h99, 32'h9);
    chk("post_flush_count", bus.count_out, 4);
    for (int i = 2; i < 6; i++) cdb(3'(i), 32'hD0 + i, 0);
    for (int i = 0; i < 4; i++) retire();
    chk("final_count", bus.count_out, 0);
    chk("sb_drained", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
